// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver: each channel has its own prescaler, mode (OFF/ON/BLINK/PWM) and duty,
// all running from one clock and reprogrammable at run time through a single-cycle write port.
module led_ctrl_multi #(
    parameter int               CH       = 4,
    parameter int               CNT_W    = 26,
    parameter int               DUTY_W   = 8,
    parameter logic [1:0]       DEF_MODE = 2'b10,
    parameter logic [CNT_W-1:0] DEF_DIV  = {CNT_W{1'b1}},
    parameter logic [DUTY_W-1:0] DEF_DUTY = DUTY_W'(1) << (DUTY_W - 1),
    localparam int              CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic [CH-1:0]     led,
    output logic [CH-1:0]     tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        mode_e             mode;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  div;
        logic [DUTY_W-1:0] duty;
        logic [DUTY_W-1:0] phase;
        logic [DUTY_W-1:0] phase_next;
        logic              led_r;
        logic              tick_r;
        logic              sel;
        logic              wrap;

        // Channel numbers at or above CH never match, so such writes fall through untouched.
        assign sel        = cfg_we && (cfg_ch == CH_W'(i));
        assign wrap       = (cnt == div);
        assign phase_next = wrap ? phase + DUTY_W'(1) : phase;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode   <= mode_e'(DEF_MODE);
                div    <= DEF_DIV;
                duty   <= DEF_DUTY;
                cnt    <= '0;
                phase  <= '0;
                led_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (sel) begin
                // A write restarts the channel and beats any wrap due on this same edge.
                mode   <= mode_e'(cfg_mode);
                div    <= cfg_div;
                duty   <= cfg_duty;
                cnt    <= '0;
                phase  <= '0;
                tick_r <= 1'b0;
                case (mode_e'(cfg_mode))
                    MODE_OFF:   led_r <= 1'b0;
                    MODE_ON:    led_r <= 1'b1;
                    MODE_BLINK: led_r <= 1'b0;
                    MODE_PWM:   led_r <= (cfg_duty != '0);
                    default:    led_r <= 1'b0;
                endcase
            end else begin
                cnt    <= wrap ? '0 : cnt + CNT_W'(1);
                tick_r <= wrap;
                case (mode)
                    MODE_OFF:   led_r <= 1'b0;
                    MODE_ON:    led_r <= 1'b1;
                    MODE_BLINK: if (wrap) led_r <= ~led_r;
                    MODE_PWM: begin
                        phase <= phase_next;
                        led_r <= (phase_next < duty);
                    end
                    default:    led_r <= 1'b0;
                endcase
            end
        end

        assign led[i]  = led_r;
        assign tick[i] = tick_r;
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Scoreboard bench for led_ctrl_multi: stimulus queues per-edge expectations, a negedge monitor
// pops and compares them against led/tick.
module tb_led_ctrl_multi;

    localparam int CH     = 3;
    localparam int CNT_W  = 4;
    localparam int DUTY_W = 8;

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PWM   = 2'b11;

    typedef struct {
        string          name;
        logic [CH-1:0]  led_m;
        logic [CH-1:0]  led_e;
        logic [CH-1:0]  tick_m;
        logic [CH-1:0]  tick_e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [DUTY_W-1:0] cfg_duty = '0;
    logic [CH-1:0]     led;
    logic [CH-1:0]     tick;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    led_ctrl_multi #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .DUTY_W  (DUTY_W),
        .DEF_MODE(2'b10),
        .DEF_DIV (4'd3),
        .DEF_DUTY(8'd128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_div (cfg_div),
        .cfg_duty(cfg_duty),
        .led     (led),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // One rising edge; the expectation queued describes the outputs right after that edge.
    task automatic cycle(input logic [CH-1:0] lm, input logic [CH-1:0] le,
                         input logic [CH-1:0] tm, input logic [CH-1:0] te, input string nm);
        exp_t e;
        @(posedge clk);
        e.name = nm; e.led_m = lm; e.led_e = le; e.tick_m = tm; e.tick_e = te;
        sb.push_back(e);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [1:0] ch, input logic [1:0] mode,
                                  input logic [CNT_W-1:0] div, input logic [DUTY_W-1:0] duty,
                                  input logic [CH-1:0] lm, input logic [CH-1:0] le,
                                  input logic [CH-1:0] tm, input logic [CH-1:0] te, input string nm);
        cfg_ch = ch; cfg_mode = mode; cfg_div = div; cfg_duty = duty; cfg_we = 1'b1;
        cycle(lm, le, tm, te, nm);
    endtask

    task automatic check_output(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // All channels share the defaults: BLINK with div=3, so tick every 4th edge and led toggling with it.
    task automatic reset_pattern(input string nm);
        for (int k = 1; k <= 8; k++) begin
            logic [CH-1:0] t;
            logic [CH-1:0] l;
            t = (k % 4 == 0) ? 3'b111 : 3'b000;
            l = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
            cycle(3'b111, l, 3'b111, t, nm);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.led_m != '0 || e.tick_m != '0) begin
                    tests_run++;
                    if ((((led ^ e.led_e) & e.led_m) != '0) || (((tick ^ e.tick_e) & e.tick_m) != '0)) begin
                        tests_failed++;
                        $display("[TB] FAIL %s: led=%b tick=%b expected led=%b tick=%b (masks %b/%b)",
                                 e.name, led, tick, e.led_e, e.tick_e, e.led_m, e.tick_m);
                    end
                end
            end
        end
    end

    initial begin
        repeat (5) cycle(3'b111, 3'b000, 3'b111, 3'b000, "in_reset");
        rst = 1'b1;
        reset_pattern("reset_release");

        apply_stimulus(2'd1, M_BLINK, 4'd0, 8'd0, 3'b010, 3'b000, 3'b010, 3'b000, "blink_div0_write");
        for (int j = 1; j <= 6; j++)
            cycle(3'b010, (j % 2 == 1) ? 3'b010 : 3'b000, 3'b010, 3'b010, "blink_div0");

        apply_stimulus(2'd2, M_PWM, 4'd0, 8'd64, 3'b100, 3'b100, 3'b100, 3'b000, "pwm64_write");
        for (int j = 1; j <= 256; j++)
            cycle(3'b100, ((j % 256) < 64) ? 3'b100 : 3'b000, 3'b100, 3'b100, "pwm64");

        apply_stimulus(2'd2, M_PWM, 4'd0, 8'd0, 3'b100, 3'b000, 3'b100, 3'b000, "pwm0_write");
        repeat (20) cycle(3'b100, 3'b000, 3'b100, 3'b100, "pwm0");

        apply_stimulus(2'd2, M_PWM, 4'd0, 8'd255, 3'b100, 3'b100, 3'b100, 3'b000, "pwm255_write");
        for (int j = 1; j <= 256; j++)
            cycle(3'b100, ((j % 256) < 255) ? 3'b100 : 3'b000, 3'b100, 3'b100, "pwm255");

        apply_stimulus(2'd0, M_BLINK, 4'd9, 8'd0, 3'b001, 3'b000, 3'b001, 3'b000, "coll_setup");
        for (int j = 1; j <= 9; j++)
            cycle(3'b001, 3'b000, 3'b001, 3'b000, "coll_count");
        apply_stimulus(2'd0, M_BLINK, 4'd5, 8'd0, 3'b001, 3'b000, 3'b001, 3'b000, "coll_write");
        for (int j = 1; j <= 5; j++)
            cycle(3'b001, 3'b000, 3'b001, 3'b000, "coll_restart");
        cycle(3'b001, 3'b001, 3'b001, 3'b001, "coll_next_tick");

        apply_stimulus(2'd0, M_ON,  4'd1, 8'd0, 3'b001, 3'b001, 3'b001, 3'b000, "prep_ch0_on");
        apply_stimulus(2'd1, M_OFF, 4'd4, 8'd0, 3'b011, 3'b001, 3'b011, 3'b000, "prep_ch1_off");
        apply_stimulus(2'd2, M_ON,  4'd2, 8'd0, 3'b111, 3'b101, 3'b111, 3'b001, "prep_ch2_on");
        apply_stimulus(2'd3, M_OFF, 4'd0, 8'd0, 3'b111, 3'b101, 3'b111, 3'b000, "illegal_write");
        cycle(3'b111, 3'b101, 3'b111, 3'b001, "illegal_after1");
        cycle(3'b111, 3'b101, 3'b111, 3'b100, "illegal_after2");
        cycle(3'b111, 3'b101, 3'b111, 3'b011, "illegal_after3");

        apply_stimulus(2'd2, M_PWM, 4'd0, 8'd255, 3'b101, 3'b101, 3'b100, 3'b000, "pre_async_write");
        cycle(3'b101, 3'b101, 3'b100, 3'b100, "pre_async_run");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("async_led", led, 3'b000);
        check_output("async_tick", tick, 3'b000);
        repeat (3) cycle(3'b111, 3'b000, 3'b111, 3'b000, "async_hold");
        rst = 1'b1;
        reset_pattern("async_defaults");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
